// File: rtl/axis_pkt_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkt_pkg
// Shared definitions for the AXI-Stream packet framer:
//   fsm_state_t : framer state (IDLE = next accept opens a packet, MID = inside)
//   pkt_cw()    : width of the packet-length port / beat counter for a given
//                 maximum packet length (clog2(max)+1, so max itself fits)
// -----------------------------------------------------------------------------
package axis_pkt_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MID  = 1'b1
  } fsm_state_t;

  function automatic int pkt_cw(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// -----------------------------------------------------------------------------
// axis_skid_buf
// Two-entry skid buffer with fully registered outputs. The output entry feeds
// m_*; the skid entry only fills when a beat arrives while the output entry is
// stalled. s_ready is a register derived from the next skid occupancy, so there
// is no combinational path from m_ready to s_ready.
// Ports:
//   aclk, resetn       : clock, asynchronous active-low reset (clears all state)
//   s_valid/s_ready/s_data : upstream handshake and payload
//   m_valid/m_ready/m_data : downstream handshake and payload
// -----------------------------------------------------------------------------
module axis_skid_buf #(
  parameter int PAYLOAD_W = 9
) (
  input  logic                 aclk,
  input  logic                 resetn,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [PAYLOAD_W-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PAYLOAD_W-1:0] m_data
);

  logic                 skid_vld_p0;
  logic [PAYLOAD_W-1:0] skid_data_p0;

  logic                 skid_vld_nx;
  logic [PAYLOAD_W-1:0] skid_data_nx;
  logic                 m_vld_nx;
  logic [PAYLOAD_W-1:0] m_data_nx;
  logic                 accept;
  logic                 out_free;

  assign accept   = s_valid && s_ready;
  assign out_free = !m_valid || m_ready;

  // s_ready is low whenever the skid entry holds a beat, so an accept never
  // coincides with a skid drain.
  always_comb begin
    skid_vld_nx  = skid_vld_p0;
    skid_data_nx = skid_data_p0;
    m_vld_nx     = m_valid;
    m_data_nx    = m_data;
    if (out_free) begin
      if (skid_vld_p0) begin
        m_vld_nx    = 1'b1;
        m_data_nx   = skid_data_p0;
        skid_vld_nx = 1'b0;
      end else if (accept) begin
        m_vld_nx  = 1'b1;
        m_data_nx = s_data;
      end else begin
        m_vld_nx = 1'b0;
      end
    end else if (accept) begin
      skid_vld_nx  = 1'b1;
      skid_data_nx = s_data;
    end
  end

  // ---- stage p0 (skid entry) / p1 (output entry) ----
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      skid_vld_p0  <= 1'b0;
      skid_data_p0 <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      s_ready      <= 1'b0;
    end else begin
      skid_vld_p0  <= skid_vld_nx;
      skid_data_p0 <= skid_data_nx;
      m_valid      <= m_vld_nx;
      m_data       <= m_data_nx;
      s_ready      <= !skid_vld_nx;
    end
  end

endmodule

// File: rtl/axis_pkt_framer.sv
// -----------------------------------------------------------------------------
// axis_pkt_framer
// Cuts a continuous AXI-Stream into packets of pkt_length beats by marking the
// last beat of each packet with tlast. The length is sampled on the first beat
// of a packet (0 -> 1, above MAX_PKT_LENGTH -> MAX_PKT_LENGTH) and held for the
// rest of it. Beats pass through a 2-entry registered skid buffer carrying
// {tdata, tlast[, tuser]}.
// Ports:
//   aclk, resetn          : clock, asynchronous active-low reset
//   pkt_length [CW]       : requested beats per packet, CW = clog2(MAX)+1
//   s_axis_*              : slave stream (tvalid, tready, tdata)
//   m_axis_*              : master stream (tvalid, tready, tlast, tdata)
//   pkt_count [32]        : packets emitted on the master side, wraps
//   busy                  : a packet is partially accepted
//   m_axis_tuser          : first beat of packet (only with AXIS_PKT_FRAMER_SOF_EN)
// Build option: define AXIS_PKT_FRAMER_SOF_EN to add the m_axis_tuser SOF flag.
// -----------------------------------------------------------------------------
module axis_pkt_framer
  import axis_pkt_pkg::*;
#(
  parameter int TDATA_WIDTH    = 8,
  parameter int MAX_PKT_LENGTH = 256
) (
  input  logic                                aclk,
  input  logic                                resetn,
  input  logic [pkt_cw(MAX_PKT_LENGTH)-1:0]   pkt_length,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic [TDATA_WIDTH-1:0]              s_axis_tdata,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tlast,
  output logic [TDATA_WIDTH-1:0]              m_axis_tdata,
  output logic [31:0]                         pkt_count,
  output logic                                busy
`ifdef AXIS_PKT_FRAMER_SOF_EN
  ,
  output logic                                m_axis_tuser
`endif
);

  localparam int CW = pkt_cw(MAX_PKT_LENGTH);
`ifdef AXIS_PKT_FRAMER_SOF_EN
  localparam int PW = TDATA_WIDTH + 2;
`else
  localparam int PW = TDATA_WIDTH + 1;
`endif

  // Clamp the requested length into [1, MAX_PKT_LENGTH].
  function automatic logic [CW-1:0] sat_len(input logic [CW-1:0] req);
    if (req == '0)
      return CW'(1);
    else if (req > CW'(MAX_PKT_LENGTH))
      return CW'(MAX_PKT_LENGTH);
    else
      return req;
  endfunction

  fsm_state_t    state, state_nx;
  logic [CW-1:0] beat_cnt, beat_cnt_nx;
  logic [CW-1:0] len_q, len_nx;
  logic [CW-1:0] eff_len;
  logic          accept;
  logic          beat_last;
`ifdef AXIS_PKT_FRAMER_SOF_EN
  logic          beat_sof;
`endif
  logic [PW-1:0] skid_in;
  logic [PW-1:0] skid_out;

  assign accept  = s_axis_tvalid && s_axis_tready;
  assign eff_len = sat_len(pkt_length);
  assign busy    = (state == MID);

  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    len_nx      = len_q;
    beat_last   = 1'b0;
`ifdef AXIS_PKT_FRAMER_SOF_EN
    beat_sof    = (state == IDLE);
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          // A one-beat packet closes on its own first beat.
          if (eff_len == CW'(1)) begin
            beat_last = 1'b1;
          end else begin
            len_nx      = eff_len;
            beat_cnt_nx = CW'(1);
            state_nx    = MID;
          end
        end
      end
      MID: begin
        if (accept) begin
          if (beat_cnt + CW'(1) == len_q) begin
            beat_last   = 1'b1;
            beat_cnt_nx = '0;
            state_nx    = IDLE;
          end else begin
            beat_cnt_nx = beat_cnt + CW'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_q    <= CW'(1);
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
      len_q    <= len_nx;
    end
  end

`ifdef AXIS_PKT_FRAMER_SOF_EN
  assign skid_in = {s_axis_tdata, beat_last, beat_sof};
  assign {m_axis_tdata, m_axis_tlast, m_axis_tuser} = skid_out;
`else
  assign skid_in = {s_axis_tdata, beat_last};
  assign {m_axis_tdata, m_axis_tlast} = skid_out;
`endif

  // ---- framing marks -> skid buffer (one-cycle accept-to-valid) ----
  axis_skid_buf #(
    .PAYLOAD_W (PW)
  ) u_skid (
    .aclk    (aclk),
    .resetn  (resetn),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .s_data  (skid_in),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  (skid_out)
  );

  // ---- emit side: count completed packets ----
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn)
      pkt_count <= '0;
    else if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
      pkt_count <= pkt_count + 32'd1;
  end

endmodule
